// File: rtl/spi_pixel_receiver_if.sv
// SPI pins from the MCU and the paced pixel-load strobes toward the SPRAM frame-buffer controller.
interface spi_pixel_receiver_if #(parameter int ADDR_W = 19);
  logic              sck;
  logic              sdi;
  logic              ncs;
  logic [ADDR_W-1:0] addressWrite;
  logic [1:0]        writeData;
  logic              load;
  logic              frameDone;
  logic              overflow;

  modport master (output sck, sdi, ncs,
                  input  addressWrite, writeData, load, frameDone, overflow);
  modport slave  (input  sck, sdi, ncs,
                  output addressWrite, writeData, load, frameDone, overflow);
endinterface

// File: rtl/spi_pixel_receiver.sv
// Deserialises 2-bit pixels from a mode-0 SPI link, tags them with a linear frame address,
// buffers them and issues load strobes no closer than LOAD_GAP mainClk cycles apart.
module spi_pixel_receiver #(
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 307200,
  parameter int FIFO_DEPTH   = 8,
  parameter int LOAD_GAP     = 4
) (
  input  logic                mainClk,
  input  logic                nreset,
  spi_pixel_receiver_if.slave bus
);
  localparam int                PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                GAP_W      = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [PTR_W:0]    FULL_CNT   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(LOAD_GAP - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        pix;
  } entry_t;

  logic sck_s1, sck_s2, sck_prev;
  logic sdi_s1, sdi_s2;
  logic ncs_s1, ncs_s2, ncs_prev;
  logic rise, cs_fall;

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_prev <= 1'b0;
      sdi_s1   <= 1'b0;
      sdi_s2   <= 1'b0;
      ncs_s1   <= 1'b0;
      ncs_s2   <= 1'b0;
      ncs_prev <= 1'b0;
    end else begin
      sck_s1   <= bus.sck;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      sdi_s1   <= bus.sdi;
      sdi_s2   <= sdi_s1;
      ncs_s1   <= bus.ncs;
      ncs_s2   <= ncs_s1;
      ncs_prev <= ncs_s2;
    end
  end

  assign rise    = sck_s2 & ~sck_prev;
  assign cs_fall = ~ncs_s2 & ncs_prev;

  // Deserialiser: bit_cnt=1 means the first (MSB) bit of a pair is held in first_bit.
  logic              bit_cnt, first_bit, push;
  logic [ADDR_W-1:0] pix_addr;
  entry_t            push_entry;

  assign push       = rise & ~ncs_s2 & ~cs_fall & bit_cnt;
  assign push_entry = '{addr: pix_addr, pix: {first_bit, sdi_s2}};

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      bit_cnt   <= 1'b0;
      first_bit <= 1'b0;
      pix_addr  <= '0;
    end else if (cs_fall) begin
      // A rise coinciding with the select edge becomes bit 0 of pixel 0.
      pix_addr <= '0;
      bit_cnt  <= rise;
      if (rise) first_bit <= sdi_s2;
    end else if (ncs_s2) begin
      bit_cnt <= 1'b0;
    end else if (rise) begin
      bit_cnt <= ~bit_cnt;
      if (!bit_cnt) first_bit <= sdi_s2;
      else          pix_addr  <= (pix_addr == LAST_ADDR) ? '0 : pix_addr + ADDR_W'(1);
    end
  end

  // Pixel FIFO; pop only looks at the count from the start of the cycle, so no bypass.
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [GAP_W-1:0] gap_cnt;
  logic             full, pop, wr_en;

  assign full  = (count == FULL_CNT);
  assign pop   = (count != '0) && (gap_cnt == '0);
  assign wr_en = push & (~full | pop);

  always_ff @(posedge mainClk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue: popped entry is staged one cycle, then presented with the load strobe.
  logic   pop_q;
  entry_t pop_entry;

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      gap_cnt          <= '0;
      pop_q            <= 1'b0;
      pop_entry        <= '0;
      bus.load         <= 1'b0;
      bus.addressWrite <= '0;
      bus.writeData    <= 2'b00;
      bus.frameDone    <= 1'b0;
      bus.overflow     <= 1'b0;
    end else begin
      pop_q <= pop;
      if (pop) begin
        pop_entry <= mem[rd_ptr];
        gap_cnt   <= GAP_RELOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
      bus.load <= pop_q;
      if (pop_q) begin
        bus.addressWrite <= pop_entry.addr;
        bus.writeData    <= pop_entry.pix;
      end
      bus.frameDone <= push & (pix_addr == LAST_ADDR);
      if (cs_fall)                  bus.overflow <= 1'b0;
      else if (push & full & ~pop)  bus.overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_pixel_receiver.sv
// Scoreboard bench: dut0 (8-pixel frame, fast pacing) and dut1 (4-deep FIFO, LOAD_GAP 64).
module tb_spi_pixel_receiver;
  localparam int ADDR_W = 19;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        pix;
  } px_t;

  logic mainClk = 1'b0;
  logic nreset  = 1'b0;
  logic sck = 1'b0, sdi = 1'b0, ncs = 1'b1;
  logic en0 = 1'b1, en1 = 1'b1;
  int   n_checks = 0, n_fail = 0;

  always #5 mainClk = ~mainClk;

  spi_pixel_receiver_if #(.ADDR_W(ADDR_W)) b0 ();
  spi_pixel_receiver_if #(.ADDR_W(ADDR_W)) b1 ();

  assign b0.sck = en0 & sck;
  assign b0.sdi = sdi;
  assign b0.ncs = ~en0 | ncs;
  assign b1.sck = en1 & sck;
  assign b1.sdi = sdi;
  assign b1.ncs = ~en1 | ncs;

  spi_pixel_receiver #(.ADDR_W(ADDR_W), .FRAME_PIXELS(8), .FIFO_DEPTH(8), .LOAD_GAP(4))
    dut0 (.mainClk(mainClk), .nreset(nreset), .bus(b0.slave));
  spi_pixel_receiver #(.ADDR_W(ADDR_W), .FRAME_PIXELS(307200), .FIFO_DEPTH(4), .LOAD_GAP(64))
    dut1 (.mainClk(mainClk), .nreset(nreset), .bus(b1.slave));

  // Reference model of dut0's address/pair tracking.
  px_t  exp0[$];
  px_t  got1[$];
  px_t  e0;
  int   m_addr = 0, m_bit = 0, fd_exp = 0, fd_seen = 0;
  logic m_first = 1'b0;
  int   cyc = 0, last0 = -1000;

  always @(posedge mainClk) cyc = cyc + 1;

  always @(negedge mainClk) begin
    if (nreset) begin
      if (b0.frameDone) fd_seen++;
      if (b0.load) begin
        n_checks++;
        if (exp0.size() == 0) begin
          n_fail++;
          $display("FAIL load0_stray: got addr=%0d data=%0d, required no load", b0.addressWrite, b0.writeData);
        end else begin
          e0 = exp0.pop_front();
          if (b0.addressWrite !== e0.addr || b0.writeData !== e0.pix) begin
            n_fail++;
            $display("FAIL load0_value: got (%0d,%0d), required (%0d,%0d)",
                     b0.addressWrite, b0.writeData, e0.addr, e0.pix);
          end
        end
        n_checks++;
        if (cyc - last0 < 4) begin
          n_fail++;
          $display("FAIL load0_spacing: got %0d cycles, required >= 4", cyc - last0);
        end
        last0 = cyc;
      end
      if (b1.load) got1.push_back('{b1.addressWrite, b1.writeData});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge mainClk);
    #1;
  endtask

  task automatic cs_low();
    ncs = 1'b0;
    if (en0) begin m_addr = 0; m_bit = 0; end
    tick(8);
  endtask

  task automatic cs_high();
    ncs   = 1'b1;
    m_bit = 0;
    tick(8);
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    tick(4);
    sck = 1'b1;
    if (en0 && !ncs) begin
      if (m_bit == 0) begin
        m_first = b;
        m_bit   = 1;
      end else begin
        exp0.push_back('{ADDR_W'(m_addr), {m_first, b}});
        if (m_addr == 7) fd_exp++;
        m_addr = (m_addr == 7) ? 0 : m_addr + 1;
        m_bit  = 0;
      end
    end
    tick(4);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic wait_drain0(input string name);
    for (int i = 0; i < 200 && exp0.size() != 0; i++) tick(1);
    tick(10);
    n_checks++;
    if (exp0.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d loads missing, required 0", name, exp0.size());
      exp0.delete();
    end
  endtask

  task automatic check_fd(input string name);
    n_checks++;
    if (fd_seen !== fd_exp) begin
      n_fail++;
      $display("FAIL %s_frameDone: got %0d pulses, required %0d", name, fd_seen, fd_exp);
    end
  endtask

  task automatic check_idle(input string name);
    logic [ADDR_W+4:0] v0, v1;
    v0 = {b0.load, b0.frameDone, b0.overflow, b0.addressWrite, b0.writeData};
    v1 = {b1.load, b1.frameDone, b1.overflow, b1.addressWrite, b1.writeData};
    n_checks++;
    if (v0 !== '0) begin
      n_fail++;
      $display("FAIL %s_dut0: got outputs %h, required 0", name, v0);
    end
    n_checks++;
    if (v1 !== '0) begin
      n_fail++;
      $display("FAIL %s_dut1: got outputs %h, required 0", name, v1);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    en0 = 1'b1;
    en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ncs = 1'b0; sdi = i[0]; sck = 1'b1; tick(3);
      sck = 1'b0; ncs = 1'b1; tick(3);
    end
    check_idle("reset_held");
    tick(2);
    nreset = 1'b1;
    tick(20);
    check_idle("reset_released");
    en1 = 1'b0;
  endtask

  task automatic test_basic();
    cs_low();
    send_byte(8'hE4);
    wait_drain0("basic");
    cs_high();
    check_fd("basic");
  endtask

  task automatic test_partial();
    cs_low();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    cs_high();
    cs_low();
    send_byte(8'h40);
    wait_drain0("partial");
    cs_high();
    check_fd("partial");
  endtask

  task automatic test_frame_wrap();
    int fd_before;
    fd_before = fd_seen;
    cs_low();
    repeat (3) send_byte(8'h00);
    wait_drain0("wrap");
    cs_high();
    check_fd("wrap");
    n_checks++;
    if (fd_seen - fd_before != 1) begin
      n_fail++;
      $display("FAIL wrap_single_frameDone: got %0d pulses, required 1", fd_seen - fd_before);
    end
  endtask

  task automatic test_overflow();
    int ok;
    en0 = 1'b0;
    en1 = 1'b1;
    got1.delete();
    cs_low();
    repeat (4) send_byte(8'h1B);
    n_checks++;
    if (b1.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b, required 1", b1.overflow);
    end
    tick(400);
    n_checks++;
    if (got1.size() < 5) begin
      n_fail++;
      $display("FAIL ovf_load_count: got %0d, required >= 5", got1.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got1[i].addr !== ADDR_W'(i) || got1[i].pix !== 2'(i % 4)) begin
          n_fail++;
          $display("FAIL ovf_first%0d: got (%0d,%0d), required (%0d,%0d)",
                   i, got1[i].addr, got1[i].pix, i, i % 4);
        end
      end
    end
    ok = 1;
    for (int i = 1; i < got1.size(); i++)
      if (got1[i].addr <= got1[i-1].addr) ok = 0;
    n_checks++;
    if (ok != 1) begin
      n_fail++;
      $display("FAIL ovf_increasing: got non-increasing addresses, required strictly increasing");
    end
    cs_high();
    n_checks++;
    if (b1.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b, required 1", b1.overflow);
    end
    cs_low();
    n_checks++;
    if (b1.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b, required 0", b1.overflow);
    end
    cs_high();
  endtask

  task automatic test_reset_midbyte();
    int  n;
    px_t want[4];
    got1.delete();
    cs_low();
    send_byte(8'hE4);
    sdi = 1'b1;
    sck = 1'b1;
    tick(4);
    n_checks++;
    if (got1.size() != 1 || got1[0].addr !== '0 || got1[0].pix !== 2'd3) begin
      n_fail++;
      $display("FAIL midrst_first_load: got %0d loads, required exactly (0,3)", got1.size());
    end
    nreset = 1'b0;
    sck    = 1'b0;
    tick(3);
    check_idle("midrst_held");
    nreset = 1'b1;
    n = got1.size();
    tick(300);
    n_checks++;
    if (got1.size() != n) begin
      n_fail++;
      $display("FAIL midrst_flushed: got %0d loads after reset, required 0", got1.size() - n);
    end
    send_byte(8'h1B);
    for (int i = 0; i < 400 && got1.size() < n + 4; i++) tick(1);
    n_checks++;
    if (got1.size() != n + 4) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d loads, required 4", got1.size() - n);
    end else begin
      for (int i = 0; i < 4; i++) want[i] = '{ADDR_W'(i), 2'(i)};
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got1[n+i].addr !== want[i].addr || got1[n+i].pix !== want[i].pix) begin
          n_fail++;
          $display("FAIL midrst_load%0d: got (%0d,%0d), required (%0d,%0d)",
                   i, got1[n+i].addr, got1[n+i].pix, want[i].addr, want[i].pix);
        end
      end
    end
    cs_high();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_frame_wrap();
    test_overflow();
    test_reset_midbyte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
